// File: rtl/riscv_pkg.sv
// Shared definitions for the load/store unit.
//   - RV32I load/store funct3 encodings (F3_*)
//   - lsu_state_e: LSU controller state encoding, also exported on the
//     debug state port of load_store_unit
package riscv_pkg;

   // Load/store width encodings. Stores only use F3_B, F3_H and F3_W.
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_MERGE  = 2'd2,
      ST_RESP   = 2'd3
   } lsu_state_e;

endpackage

// File: rtl/load_store_unit_if.sv
// Bus bundle between execute stage, load/store unit and data memory.
//
// Request channel (execute -> LSU): req_valid, req_store, req_funct3,
//   req_addr, req_wdata forward; req_ready back.
// Response channel (LSU -> writeback): resp_valid, resp_rdata, resp_err
//   forward; resp_ready back.
// Memory channel (LSU -> memory): mem_addr, mem_wdata, mem_wr_en forward;
//   mem_rdata back (combinational read of mem_addr).
//
// Handshake: a transfer happens on a rising clk edge where valid && ready
// are both high. The sender holds its payload stable while valid is high
// and ready is low; the LSU keeps resp_* stable until resp_ready.
//
// Modports: slave = LSU, master = execute/writeback side, memory = RAM.
interface load_store_unit_if #(
   parameter int MEM_DEPTH_LOG2 = 5
);
   logic                      req_valid;
   logic                      req_ready;
   logic                      req_store;
   logic [2:0]                req_funct3;
   logic [31:0]               req_addr;
   logic [31:0]               req_wdata;

   logic [MEM_DEPTH_LOG2-1:0] mem_addr;
   logic [31:0]               mem_wdata;
   logic                      mem_wr_en;
   logic [31:0]               mem_rdata;

   logic                      resp_valid;
   logic                      resp_ready;
   logic [31:0]               resp_rdata;
   logic                      resp_err;

   modport slave (
      input  req_valid, req_store, req_funct3, req_addr, req_wdata,
      input  mem_rdata, resp_ready,
      output req_ready, mem_addr, mem_wdata, mem_wr_en,
      output resp_valid, resp_rdata, resp_err
   );

   modport master (
      output req_valid, req_store, req_funct3, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport memory (
      input  mem_addr, mem_wdata, mem_wr_en,
      output mem_rdata
   );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit.
//   chk_store/chk_funct3/chk_off : incoming request, checked for misalignment
//   funct3/off                    : latched operation width and byte offset
//   ld_word                       : memory word being loaded
//   mg_word                       : captured word for a byte/half store
//   st_data                       : store data (rs2)
//   load_data                     : selected lane, sign/zero extended
//   merge_data                    : mg_word with target lane(s) replaced
//   misaligned                    : request is misaligned or has an
//                                   undefined funct3 for its direction
module lsu_align
   import riscv_pkg::*;
(
   input  logic        chk_store,
   input  logic [2:0]  chk_funct3,
   input  logic [1:0]  chk_off,
   input  logic [2:0]  funct3,
   input  logic [1:0]  off,
   input  logic [31:0] ld_word,
   input  logic [31:0] mg_word,
   input  logic [31:0] st_data,
   output logic [31:0] load_data,
   output logic [31:0] merge_data,
   output logic        misaligned
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   always_comb begin
      ld_byte = ld_word[{off, 3'b000} +: 8];
      ld_half = off[1] ? ld_word[31:16] : ld_word[15:0];

      load_data = 32'd0;
      case (funct3)
         F3_B:    load_data = {{24{ld_byte[7]}}, ld_byte};
         F3_BU:   load_data = {24'd0, ld_byte};
         F3_H:    load_data = {{16{ld_half[15]}}, ld_half};
         F3_HU:   load_data = {16'd0, ld_half};
         F3_W:    load_data = ld_word;
         default: load_data = 32'd0;
      endcase
   end

   always_comb begin
      merge_data = mg_word;
      case (funct3)
         F3_B:    merge_data[{off, 3'b000} +: 8]   = st_data[7:0];
         F3_H:    merge_data[{off[1], 4'b0000} +: 16] = st_data[15:0];
         F3_W:    merge_data = st_data;
         default: merge_data = mg_word;
      endcase
   end

   // Unsigned widths only exist for loads, so LBU/LHU encodings on a store
   // are undefined and reported like a misalignment.
   always_comb begin
      misaligned = 1'b1;
      case (chk_funct3)
         F3_B:    misaligned = 1'b0;
         F3_H:    misaligned = chk_off[0];
         F3_W:    misaligned = (chk_off != 2'b00);
         F3_BU:   misaligned = chk_store;
         F3_HU:   misaligned = chk_store | chk_off[0];
         default: misaligned = 1'b1;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte-addressed RV32I loads/stores into
// word-granular accesses to a 2**MEM_DEPTH_LOG2-word data memory.
//   clk       : rising-edge clock
//   reset     : asynchronous, active-low reset
//   bus       : request / memory / response signals (slave modport)
//   dbg_state : current controller state
//
// Flow: IDLE accepts one request. Loads and SW spend one cycle in ACCESS;
// SB/SH read the word in ACCESS and write the merged word in MERGE.
// Misaligned requests go straight to RESP without touching memory.
// RESP holds the result until resp_ready; one request in flight at most.
module load_store_unit
   import riscv_pkg::*;
#(
   parameter int MEM_DEPTH_LOG2 = 5
) (
   input  logic              clk,
   input  logic              reset,
   load_store_unit_if.slave  bus,
   output lsu_state_e        dbg_state
);

   lsu_state_e                state_q, state_d;
   logic                      store_q, store_d;
   logic [2:0]                funct3_q, funct3_d;
   logic [1:0]                off_q, off_d;
   logic [31:0]               wdata_q, wdata_d;
   logic [31:0]               merge_q, merge_d;
   logic [31:0]               rdata_q, rdata_d;
   logic                      err_q, err_d;
   logic [MEM_DEPTH_LOG2-1:0] mem_addr_q, mem_addr_d;

   logic                      req_ready_c;
   logic                      mem_wr_en_c;
   logic [31:0]               mem_wdata_c;

   logic [31:0]               load_data;
   logic [31:0]               merge_data;
   logic                      misaligned;

   lsu_align u_align (
      .chk_store  (bus.req_store),
      .chk_funct3 (bus.req_funct3),
      .chk_off    (bus.req_addr[1:0]),
      .funct3     (funct3_q),
      .off        (off_q),
      .ld_word    (bus.mem_rdata),
      .mg_word    (merge_q),
      .st_data    (wdata_q),
      .load_data  (load_data),
      .merge_data (merge_data),
      .misaligned (misaligned)
   );

   always_comb begin
      state_d    = state_q;
      store_d    = store_q;
      funct3_d   = funct3_q;
      off_d      = off_q;
      wdata_d    = wdata_q;
      merge_d    = merge_q;
      rdata_d    = rdata_q;
      err_d      = err_q;
      mem_addr_d = mem_addr_q;

      req_ready_c = 1'b0;
      mem_wr_en_c = 1'b0;
      // Whenever we are not writing, echo the read word back so a memory
      // that writes every cycle just rewrites its own contents.
      mem_wdata_c = bus.mem_rdata;

      case (state_q)
         ST_IDLE: begin
            req_ready_c = 1'b1;
            if (bus.req_valid) begin
               store_d  = bus.req_store;
               funct3_d = bus.req_funct3;
               off_d    = bus.req_addr[1:0];
               wdata_d  = bus.req_wdata;
               // Stores and errors return zero data; loads overwrite later.
               rdata_d  = 32'd0;
               err_d    = misaligned;
               if (misaligned) begin
                  state_d = ST_RESP;
               end else begin
                  // Upper address bits are dropped: the memory aliases.
                  mem_addr_d = bus.req_addr[MEM_DEPTH_LOG2+1:2];
                  state_d    = ST_ACCESS;
               end
            end
         end

         ST_ACCESS: begin
            if (!store_q) begin
               rdata_d = load_data;
               state_d = ST_RESP;
            end else if (funct3_q == F3_W) begin
               mem_wr_en_c = 1'b1;
               mem_wdata_c = wdata_q;
               state_d     = ST_RESP;
            end else begin
               merge_d = bus.mem_rdata;
               state_d = ST_MERGE;
            end
         end

         ST_MERGE: begin
            mem_wr_en_c = 1'b1;
            mem_wdata_c = merge_data;
            state_d     = ST_RESP;
         end

         ST_RESP: begin
            if (bus.resp_ready) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         store_q    <= 1'b0;
         funct3_q   <= 3'd0;
         off_q      <= 2'd0;
         wdata_q    <= 32'd0;
         merge_q    <= 32'd0;
         rdata_q    <= 32'd0;
         err_q      <= 1'b0;
         mem_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         store_q    <= store_d;
         funct3_q   <= funct3_d;
         off_q      <= off_d;
         wdata_q    <= wdata_d;
         merge_q    <= merge_d;
         rdata_q    <= rdata_d;
         err_q      <= err_d;
         mem_addr_q <= mem_addr_d;
      end
   end

   assign bus.req_ready  = req_ready_c;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_c;
   assign bus.mem_wr_en  = mem_wr_en_c;
   assign bus.resp_valid = (state_q == ST_RESP);
   assign bus.resp_rdata = rdata_q;
   assign bus.resp_err   = err_q;
   assign dbg_state      = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
   import riscv_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   load_store_unit_if #(.MEM_DEPTH_LOG2(5)) bus ();
   lsu_state_e dbg_state;

   load_store_unit #(.MEM_DEPTH_LOG2(5)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // ---------------- data memory + write monitor ----------------
   logic [31:0] mem     [32];
   logic [31:0] ref_mem [32];
   logic        load_img = 1'b0;
   int          wr_count = 0;
   logic [31:0] last_wdata;
   lsu_state_e  last_wr_state;
   logic [4:0]  last_wr_addr;

   assign bus.mem_rdata = mem[bus.mem_addr];

   always @(posedge clk) begin
      if (load_img) begin
         for (int i = 0; i < 32; i++) mem[i] <= ref_mem[i];
      end else if (bus.mem_wr_en) begin
         mem[bus.mem_addr] <= bus.mem_wdata;
         wr_count          <= wr_count + 1;
         last_wdata        <= bus.mem_wdata;
         last_wr_state     <= dbg_state;
         last_wr_addr      <= bus.mem_addr;
      end
   end

   // ---------------- scoreboard ----------------
   logic [32:0] exp_q [$];   // {err, rdata}
   int          lat_q [$];
   int          checks   = 0;
   int          failures = 0;
   logic [2:0]  f3_tab [5] = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference behaviour of the unit, written independently of the RTL.
   function automatic logic model_err(input logic st, input logic [2:0] f3, input logic [31:0] a);
      case (f3)
         3'b000:  return 1'b0;
         3'b001:  return a[0];
         3'b010:  return (a[1:0] != 2'b00);
         3'b100:  return st;
         3'b101:  return st | a[0];
         default: return 1'b1;
      endcase
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] w);
      logic [31:0] sh;
      sh = w >> (8 * off);
      case (f3)
         3'b000:  return {{24{sh[7]}}, sh[7:0]};
         3'b100:  return {24'd0, sh[7:0]};
         3'b001:  return {{16{sh[15]}}, sh[15:0]};
         3'b101:  return {16'd0, sh[15:0]};
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] model_store(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] w, input logic [31:0] wd);
      logic [31:0] m;
      logic [31:0] d;
      case (f3)
         3'b000:  m = 32'h0000_00FF;
         3'b001:  m = 32'h0000_FFFF;
         default: m = 32'hFFFF_FFFF;
      endcase
      m = m << (8 * off);
      d = wd << (8 * off);
      return (w & ~m) | (d & m);
   endfunction

   // ---------------- driver: one complete request ----------------
   // hold > 0 keeps resp_ready low for that many cycles after resp_valid,
   // while presenting a competing SW that must be ignored.
   task automatic run_req(input string tag, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd, input int hold);
      logic        exp_err;
      logic [31:0] exp_data;
      logic [4:0]  widx;
      int          exp_lat;
      int          exp_wr;
      int          lat;
      int          wr0;
      logic [32:0] item;
      lsu_state_e  exp_wr_state;

      widx     = addr[6:2];
      exp_err  = model_err(st, f3, addr);
      exp_data = 32'd0;
      if (!exp_err && !st) exp_data = model_load(f3, addr[1:0], ref_mem[widx]);
      exp_lat  = exp_err ? 1 : ((st && f3 != F3_W) ? 3 : 2);
      exp_wr   = (st && !exp_err) ? 1 : 0;
      exp_wr_state = (f3 == F3_W) ? ST_ACCESS : ST_MERGE;
      if (exp_wr == 1) ref_mem[widx] = model_store(f3, addr[1:0], ref_mem[widx], wd);
      exp_q.push_back({exp_err, exp_data});
      lat_q.push_back(exp_lat);
      wr0 = wr_count;

      check({tag, " req_ready_idle"}, 32'(bus.req_ready), 32'd1);
      bus.req_valid  = 1'b1;
      bus.req_store  = st;
      bus.req_funct3 = f3;
      bus.req_addr   = addr;
      bus.req_wdata  = wd;
      bus.resp_ready = (hold == 0);
      step();
      bus.req_valid = 1'b0;
      lat = 1;
      while (bus.resp_valid !== 1'b1 && lat < 12) begin
         step();
         lat++;
      end

      item = exp_q.pop_front();
      check({tag, " latency"}, lat, lat_q.pop_front());
      check({tag, " rdata"}, bus.resp_rdata, item[31:0]);
      check({tag, " err"}, 32'(bus.resp_err), 32'(item[32]));

      if (hold > 0) begin
         bus.req_valid  = 1'b1;
         bus.req_store  = 1'b1;
         bus.req_funct3 = F3_W;
         bus.req_addr   = addr ^ 32'h0000_0010;
         bus.req_wdata  = 32'hDEAD_BEEF;
         for (int i = 0; i < hold; i++) begin
            step();
            check({tag, " hold_valid"}, 32'(bus.resp_valid), 32'd1);
            check({tag, " hold_rdata"}, bus.resp_rdata, item[31:0]);
            check({tag, " hold_err"}, 32'(bus.resp_err), 32'(item[32]));
            check({tag, " hold_req_ready"}, 32'(bus.req_ready), 32'd0);
         end
         bus.req_valid  = 1'b0;
         bus.resp_ready = 1'b1;
      end

      step();
      check({tag, " resp_drop"}, 32'(bus.resp_valid), 32'd0);
      check({tag, " back_idle"}, 32'(bus.req_ready), 32'd1);
      check({tag, " write_count"}, wr_count - wr0, exp_wr);
      if (exp_wr == 1) begin
         check({tag, " write_data"}, last_wdata, ref_mem[widx]);
         check({tag, " write_state"}, 32'(last_wr_state), 32'(exp_wr_state));
         check({tag, " write_addr"}, 32'(last_wr_addr), 32'(widx));
      end
      check({tag, " mem_word"}, mem[widx], ref_mem[widx]);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int wr0;
      bus.req_valid  = 1'b0;
      bus.req_store  = 1'b0;
      bus.req_funct3 = 3'd0;
      bus.req_addr   = 32'd0;
      bus.req_wdata  = 32'd0;
      bus.resp_ready = 1'b1;
      for (int i = 0; i < 32; i++) ref_mem[i] = $urandom();
      ref_mem[2] = 32'h8899_AABB;
      load_img   = 1'b1;
      reset      = 1'b0;
      repeat (3) step();

      check("rst mem_wr_en", 32'(bus.mem_wr_en), 32'd0);
      check("rst mem_addr", 32'(bus.mem_addr), 32'd0);
      check("rst resp_valid", 32'(bus.resp_valid), 32'd0);
      check("rst resp_rdata", bus.resp_rdata, 32'd0);
      check("rst resp_err", 32'(bus.resp_err), 32'd0);
      load_img = 1'b0;
      reset    = 1'b1;
      step();
      check("post_rst req_ready", 32'(bus.req_ready), 32'd1);
      check("post_rst state", 32'(dbg_state), 32'(ST_IDLE));

      // Loads of word 2 = 0x8899_AABB
      run_req("lw_08",  1'b0, F3_W,  32'h0000_0008, 32'd0, 0);
      run_req("lb_0b",  1'b0, F3_B,  32'h0000_000B, 32'd0, 0);
      run_req("lbu_0b", 1'b0, F3_BU, 32'h0000_000B, 32'd0, 0);
      run_req("lh_0a",  1'b0, F3_H,  32'h0000_000A, 32'd0, 0);
      run_req("lhu_08", 1'b0, F3_HU, 32'h0000_0008, 32'd0, 0);
      // Read-modify-write byte store, then read back
      run_req("sb_09",  1'b1, F3_B,  32'h0000_0009, 32'h0000_005A, 0);
      run_req("lw_after_sb", 1'b0, F3_W, 32'h0000_0008, 32'd0, 0);
      run_req("sh_0e",  1'b1, F3_H,  32'h0000_000E, 32'hCAFE_1234, 0);
      run_req("sw_10",  1'b1, F3_W,  32'h0000_0010, 32'h1357_9BDF, 0);
      run_req("lw_0c",  1'b0, F3_W,  32'h0000_000C, 32'd0, 0);
      // Aliasing: upper address bits ignored (word 4 again)
      run_req("lw_alias", 1'b0, F3_W, 32'hFFFF_FF90, 32'd0, 0);
      // Misaligned / undefined encodings
      run_req("lw_06_err",  1'b0, F3_W,   32'h0000_0006, 32'd0, 0);
      run_req("sh_03_err",  1'b1, F3_H,   32'h0000_0003, 32'hFFFF_FFFF, 0);
      run_req("f3_011_err", 1'b0, 3'b011, 32'h0000_0008, 32'd0, 0);
      run_req("sbu_err",    1'b1, F3_BU,  32'h0000_0008, 32'h0000_00FF, 0);
      // Back-pressure on the response port
      run_req("lh_hold", 1'b0, F3_H, 32'h0000_000A, 32'd0, 4);

      // Random mix
      for (int n = 0; n < 14; n++) begin
         logic        rst_st;
         logic [2:0]  rf3;
         logic [31:0] ra;
         rst_st = 1'($urandom_range(0, 1));
         rf3    = rst_st ? f3_tab[$urandom_range(0, 2)] : f3_tab[$urandom_range(0, 4)];
         ra     = $urandom();
         if ($urandom_range(0, 3) != 0) begin
            if (rf3 == F3_W) ra[1:0] = 2'b00;
            else if (rf3 == F3_H || rf3 == F3_HU) ra[0] = 1'b0;
         end
         run_req($sformatf("rand_%0d", n), rst_st, rf3, ra, $urandom(), 0);
      end

      // Reset in ACCESS of an SB: the merge write must never happen
      wr0 = wr_count;
      bus.req_valid  = 1'b1;
      bus.req_store  = 1'b1;
      bus.req_funct3 = F3_B;
      bus.req_addr   = 32'h0000_0009;
      bus.req_wdata  = 32'h0000_00A5;
      bus.resp_ready = 1'b1;
      step();
      bus.req_valid = 1'b0;
      check("rstmid in_access", 32'(dbg_state), 32'(ST_ACCESS));
      reset = 1'b0;
      #1;
      check("rstmid state", 32'(dbg_state), 32'(ST_IDLE));
      check("rstmid mem_wr_en", 32'(bus.mem_wr_en), 32'd0);
      check("rstmid mem_addr", 32'(bus.mem_addr), 32'd0);
      check("rstmid resp_valid", 32'(bus.resp_valid), 32'd0);
      check("rstmid resp_rdata", bus.resp_rdata, 32'd0);
      check("rstmid resp_err", 32'(bus.resp_err), 32'd0);
      repeat (2) step();
      reset = 1'b1;
      step();
      check("rstmid req_ready", 32'(bus.req_ready), 32'd1);
      check("rstmid no_write", wr_count - wr0, 32'd0);
      check("rstmid word2", mem[2], ref_mem[2]);
      run_req("lw_after_rst", 1'b0, F3_W, 32'h0000_0008, 32'd0, 0);

      check("scoreboard empty", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
